// File: rtl/fsgnj_pipe.sv
// fsgnj_pipe
//   Pipelined RISC-V sign-injection unit (FSGNJ / FSGNJN / FSGNJX) for any
//   IEEE-754 width. The result is formed combinationally from rs1/rs2 and then
//   carried through STAGES elastic register slots together with a destination
//   tag and an illegal-op flag.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   EN              unit enable; low freezes every slot and blocks both transfers
//   in_valid/ready  input handshake; rs1 (magnitude), rs2 (sign), funct3, in_tag
//   out_valid/ready output handshake; OUT_FSGNJ, out_tag, out_illegal
module fsgnj_pipe #(
  parameter int FLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLEN-1:0]  rs1,
  input  logic [FLEN-1:0]  rs2,
  input  logic [2:0]       funct3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  OUT_FSGNJ,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] OP_FSGNJ  = 3'b000;
  localparam logic [2:0] OP_FSGNJN = 3'b001;
  localparam logic [2:0] OP_FSGNJX = 3'b010;

  logic [FLEN-1:0] res_data;
  logic            res_illegal;

  always_comb begin
    res_data    = '0;
    res_illegal = 1'b0;
    case (funct3)
      OP_FSGNJ:  res_data = {rs2[FLEN-1], rs1[FLEN-2:0]};
      OP_FSGNJN: res_data = {~rs2[FLEN-1], rs1[FLEN-2:0]};
      OP_FSGNJX: res_data = {rs1[FLEN-1] ^ rs2[FLEN-1], rs1[FLEN-2:0]};
      default:   res_illegal = 1'b1;
    endcase
  end

  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] load_vec;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gen_slot
      logic             valid_q, valid_d;
      logic             ill_q, ill_d;
      logic [FLEN-1:0]  data_q, data_d;
      logic [TAG_W-1:0] tag_q, tag_d;

      logic             src_valid;
      logic             src_ill;
      logic [FLEN-1:0]  src_data;
      logic [TAG_W-1:0] src_tag;

      if (gi == 0) begin : g_src_in
        assign src_valid = in_valid;
        assign src_ill   = res_illegal;
        assign src_data  = res_data;
        assign src_tag   = in_tag;
      end else begin : g_src_prev
        assign src_valid = gen_slot[gi-1].valid_q;
        assign src_ill   = gen_slot[gi-1].ill_q;
        assign src_data  = gen_slot[gi-1].data_q;
        assign src_tag   = gen_slot[gi-1].tag_q;
      end

      // A slot may load when it, or any slot downstream of it, has a hole, or
      // when the output drains: that is the unrolled form of "empty or
      // advancing", and it depends only on flops so no combinational chain.
      assign load_vec[gi]  = EN & (out_ready | ~(&valid_vec[STAGES-1:gi]));
      assign valid_vec[gi] = valid_q;

      always_comb begin
        valid_d = valid_q;
        ill_d   = ill_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (load_vec[gi]) begin
          valid_d = src_valid;
          // Payload only moves with a real op so a drained output keeps
          // showing its last result instead of bubble contents.
          if (src_valid) begin
            ill_d  = src_ill;
            data_d = src_data;
            tag_d  = src_tag;
          end
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          valid_q <= 1'b0;
          ill_q   <= 1'b0;
          data_q  <= '0;
          tag_q   <= '0;
        end else begin
          valid_q <= valid_d;
          ill_q   <= ill_d;
          data_q  <= data_d;
          tag_q   <= tag_d;
        end
      end
    end
  endgenerate

  assign in_ready    = load_vec[0] & ~RST;
  assign out_valid   = gen_slot[STAGES-1].valid_q;
  assign OUT_FSGNJ   = gen_slot[STAGES-1].data_q;
  assign out_tag     = gen_slot[STAGES-1].tag_q;
  assign out_illegal = gen_slot[STAGES-1].ill_q;

endmodule

// File: doc/fsgnj_pipe.md
Name: fsgnj_pipe

Overview:
- Parametrised, pipelined successor to the single-mode sign-injection unit in the Floating ALU.
- Implements all three RISC-V sign-injection ops (FSGNJ, FSGNJN, FSGNJX) for any IEEE-754 width, selected per operation by funct3.
- Valid/ready elastic pipeline with a result tag, so it can sit behind the FP issue stage and drain into the shared FP writeback arbiter under back-pressure.

Parameters:
FLEN, 32, operand/result width in bits; sign bit is FLEN-1 (16, 32, 64 supported)
STAGES, 2, pipeline depth in register stages, legal range 1..4
TAG_W, 5, width of the destination-register tag carried alongside each op

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-high reset
EN  input  1  unit enable; low freezes the whole pipeline
in_valid  input  1  operation present on inputs
in_ready  output  1  unit accepts operation this cycle
rs1  input  FLEN  magnitude source operand
rs2  input  FLEN  sign source operand
funct3  input  3  op select: 000 FSGNJ, 001 FSGNJN, 010 FSGNJX, others illegal
in_tag  input  TAG_W  destination tag
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
OUT_FSGNJ  output  FLEN  result
out_tag  output  TAG_W  tag of the result
out_illegal  output  1  result came from an illegal funct3

Behaviour:
- Reset: RST high asynchronously clears every stage valid bit and every data/tag/illegal register. Outputs read out_valid=0, OUT_FSGNJ=0, out_tag=0, out_illegal=0. in_ready=0 while RST is high.
- Result, with s = rs2[FLEN-1] and m = rs1[FLEN-2:0]:
  - 000: {s, m}
  - 001: {~s, m}
  - 010: {rs1[FLEN-1]^s, m}
  - illegal funct3: result 0, out_illegal=1.
- Results are computed combinationally at stage 0 input. NaN/inf/denormal get no special treatment; these are bit operations only.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Pipeline: STAGES register slots, each {valid, data, tag, illegal}.
  - Slot k loads from slot k-1 (slot 0 from inputs) when slot k is empty or slot k itself advances this cycle.
  - The last slot advances on out_ready.
  - in_ready = EN & (slot0 empty | slot0 advances) & ~RST.
- Latency: an accepted op appears on the outputs exactly STAGES cycles after acceptance when there is no back-pressure. Throughput is 1 op/cycle.
- Back-pressure:
  - While out_valid & ~out_ready, OUT_FSGNJ, out_tag and out_illegal are held stable.
  - Bubbles compress: upstream slots keep filling until all STAGES slots are full, then in_ready drops.
  - No op is dropped or duplicated.
- Ordering: results leave strictly in acceptance order.
- EN low:
  - No slot changes and in_ready=0.
  - out_valid and the output data keep their current values.
  - An output transfer that would occur (out_ready=1) is not consumed. Downstream must qualify with EN, or the unit owner ties EN high during normal operation.
- Simultaneous accept and emit with all slots full: allowed. Every slot shifts in the same cycle, keeping a full 1/cycle stream.
- Reset mid-operation: all in-flight ops are discarded. out_valid falls asynchronously with RST. No result is emitted after RST deasserts until a new op is accepted.
- STAGES=1: a single slot. in_ready = EN & (~out_valid | out_ready).

Test Plan:
- FSGNJ, FLEN=32: rs1=0x40866666 (4.2), rs2=0xBF000000 (-0.5), funct3=000, tag=7 -> after 2 cycles out_valid=1, OUT_FSGNJ=0xC0866666, out_tag=7.
- FSGNJN/FSGNJX back-to-back, out_ready=1:
  - cycle 0: rs1=0x40866666, rs2=0xBF000000, 001 -> 0x40866666
  - cycle 1: rs1=0xC0CCCCCC, rs2=0xBF000000, 010 -> 0x40CCCCCC
  - results appear on consecutive cycles, in order.
- Back-pressure: stream 4 ops with tags 1..4, hold out_ready=0 -> in_ready falls after 2 acceptances; first result held stable. Then release out_ready -> tags 1,2,3,4 emerge in order, none lost.
- Illegal op: funct3=011, rs1=0x3F800000 -> OUT_FSGNJ=0, out_illegal=1, tag preserved. A following legal op has out_illegal=0.
- Reset mid-flight: accept 2 ops, then assert RST asynchronously between edges -> out_valid=0 immediately, outputs 0. After release, no stale results appear; a new op completes with 2-cycle latency.
- Width/EN:
  - FLEN=64, STAGES=1: rs1=0x4010CCCCCCCCCCCD, rs2=0x8000000000000000, 000 -> 0xC010CCCCCCCCCCCD after 1 cycle.
  - Drop EN for 3 cycles mid-stream -> pipeline frozen, in_ready=0, no transfers, order resumes intact.
